// File: rtl/i2c_bus_arbiter_if.sv
// i2c_bus_arbiter_if: requester-side and i2c_master-side signals of the arbiter.
// The master modport is the arbiter's view; slave is the surrounding logic.
interface i2c_bus_arbiter_if #(parameter int NUM_REQ = 2);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   req_rw;
    logic [7*NUM_REQ-1:0] req_addr;
    logic [8*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   done;
    logic                 err;
    logic [7:0]           rdata;
    logic                 m_enable;
    logic                 m_rw;
    logic [6:0]           m_addr;
    logic [7:0]           m_data_in;
    logic                 m_busy;
    logic [7:0]           m_data_out;
    modport master (
        input  req, req_rw, req_addr, req_wdata, m_busy, m_data_out,
        output gnt, done, err, rdata, m_enable, m_rw, m_addr, m_data_in
    );
    modport slave (
        output req, req_rw, req_addr, req_wdata, m_busy, m_data_out,
        input  gnt, done, err, rdata, m_enable, m_rw, m_addr, m_data_in
    );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: round-robin sharing of one i2c_master among NUM_REQ requesters.
// Optional busy-rise timeout enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_bus_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int BUSY_WAIT = 255
) (
    input logic clk,
    input logic areset,
    i2c_bus_arbiter_if.master bus
);
    localparam int PW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, ISSUE, RUN, FINISH} state_t;
    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] g;
    logic [PW-1:0] sel;
    logic          found;
    int            idx;
`ifdef I2C_ARB_TIMEOUT_EN
    localparam int CW = ($clog2(BUSY_WAIT + 1) > 8) ? $clog2(BUSY_WAIT + 1) : 8;
    logic [CW-1:0] cnt;
`endif
    // First requester at or after ptr, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                sel   = PW'(idx);
            end
        end
    end
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state         <= IDLE;
            ptr           <= '0;
            g             <= '0;
            bus.gnt       <= '0;
            bus.done      <= '0;
            bus.err       <= 1'b0;
            bus.rdata     <= '0;
            bus.m_enable  <= 1'b0;
            bus.m_rw      <= 1'b0;
            bus.m_addr    <= '0;
            bus.m_data_in <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt           <= '0;
`endif
        end else begin
            bus.done <= '0;
            bus.err  <= 1'b0;
            case (state)
                IDLE: if (found) begin
                    g             <= sel;
                    bus.gnt       <= NUM_REQ'(1) << sel;
                    bus.m_enable  <= 1'b1;
                    bus.m_rw      <= bus.req_rw[sel];
                    bus.m_addr    <= bus.req_addr[int'(sel)*7 +: 7];
                    bus.m_data_in <= bus.req_wdata[int'(sel)*8 +: 8];
                    state         <= ISSUE;
`ifdef I2C_ARB_TIMEOUT_EN
                    cnt           <= '0;
`endif
                end
                ISSUE: if (bus.m_busy) begin
                    bus.m_enable <= 1'b0;
                    state        <= RUN;
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (cnt == CW'(BUSY_WAIT - 1)) begin
                    bus.m_enable <= 1'b0;
                    bus.done     <= bus.gnt;
                    bus.err      <= 1'b1;
                    state        <= FINISH;
                end else cnt <= cnt + 1'b1;
`endif
                // done and rdata are registered so they are valid during FINISH.
                RUN: if (!bus.m_busy) begin
                    bus.done  <= bus.gnt;
                    bus.rdata <= bus.m_rw ? bus.m_data_out : bus.rdata;
                    state     <= FINISH;
                end
                default: begin
                    bus.gnt <= '0;
                    ptr     <= (g == PW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
Shares the single i2c_master between NUM_REQ independent requesters. Each requester posts one I2C transaction (rw, 7-bit address, write byte). The arbiter grants one requester at a time in round-robin order and drives the master's enable/rw/addr/data_in. It tracks the master's busy to detect completion and returns read data with a per-requester done pulse. It sits between user logic and i2c_master; the translator and slaves downstream are unchanged.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
BUSY_WAIT, 255, max clk cycles to wait for m_busy to rise after enable (timeout feature only)

Ports:
clk  in  1  system clock
areset  in  1  asynchronous active-high reset
req  in  NUM_REQ  per-requester transaction request, level
req_rw  in  NUM_REQ  per-requester direction, 1=read
req_addr  in  7*NUM_REQ  per-requester slave address, requester i at bits [7i+6:7i]
req_wdata  in  8*NUM_REQ  per-requester write byte, requester i at bits [8i+7:8i]
gnt  out  NUM_REQ  one-hot grant, held for the whole transaction
done  out  NUM_REQ  one-cycle completion pulse to the granted requester
err  out  1  one-cycle pulse with done when the transaction timed out (0 when feature off)
rdata  out  8  read byte, valid on the done cycle of a read, held until next read completes
m_enable  out  1  to i2c_master enable
m_rw  out  1  to i2c_master rw
m_addr  out  7  to i2c_master addr
m_data_in  out  8  to i2c_master data_in
m_busy  in  1  from i2c_master busy
m_data_out  in  8  from i2c_master data_out

Behaviour:
- Reset (async, areset=1): state IDLE; gnt, done, err, m_enable, m_rw = 0; m_addr, m_data_in, rdata = 0; round-robin pointer = 0 (requester 0 highest priority). Reset mid-transaction abandons it silently, with no done pulse.
- FSM states: IDLE, ISSUE, RUN, FINISH.
- IDLE: when any req bit is set, select the first set bit searching ptr, ptr+1, …, wrapping modulo NUM_REQ. Latch that requester's rw/addr/wdata into m_rw/m_addr/m_data_in. Set gnt one-hot and m_enable=1, then go to ISSUE. Latency from req to gnt/m_enable is 1 clk.
- ISSUE: hold m_enable=1 and the latched fields until m_busy=1. On m_busy=1, drop m_enable and go to RUN.
- RUN: wait for m_busy=0, then go to FINISH.
- FINISH: pulse done[g]=1 for 1 clk. If m_rw=1, load rdata from m_data_out. Clear gnt, set ptr=g+1 mod NUM_REQ, and return to IDLE. No new grant is issued in the FINISH cycle, so there is at least one idle clk between transactions.
- m_addr, m_rw and m_data_in stay stable from grant until FINISH. Requester inputs change freely after grant and are ignored.
- If a requester drops req after grant, the transaction still completes and done still pulses.
- If req of the requester that just finished is still high, it is treated as a new request, subject to round robin.
- Simultaneous requests are resolved only by the pointer. No requester waits more than NUM_REQ-1 transactions.
- m_busy already high in IDLE, e.g. a stale master: no effect until a grant. ISSUE then advances on the first cycle.

Optional Feature:
Macro I2C_ARB_TIMEOUT_EN.
- Defined: an 8+-bit counter runs in ISSUE. If m_busy has not risen after BUSY_WAIT clks, drop m_enable and go to FINISH with err=1 alongside done. rdata is not updated on a timeout.
- Not defined: no counter. ISSUE waits indefinitely and err is tied 0.

Test Plan:
- Reset then idle: all outputs 0 and gnt stays 0 for 20 clks with req=0.
- Single write: req[0]=1, rw=0, addr=0x50, wdata=0xA5. Next clk gnt=01, m_enable=1, m_addr=0x50, m_data_in=0xA5. m_enable drops after busy rises. One done[0] pulse follows busy falling; rdata unchanged.
- Read: req[1]=1, rw=1, addr=0x3C. The master model returns 0x5A. done[1] pulses and rdata=0x5A on that cycle and afterwards.
- Contention: req=11 held continuously for 4 transactions. Grant order is 0,1,0,1, and there is ≥1 idle clk between gnt deassert and the next gnt.
- Reset mid-RUN: assert areset while busy=1. gnt, m_enable and done are 0 immediately and asynchronously. After release, req=10 is granted to requester 1; with both requesting, requester 0 is granted first.
- With I2C_ARB_TIMEOUT_EN and BUSY_WAIT=10: hold m_busy=0 after grant. After 10 clks m_enable drops, done and err pulse together, and rdata is unchanged.
